// File: rtl/cpu_defs.sv
// Shared definitions for the decode stage: ALU op codes, RV32I opcodes,
// immediate formats and the ID/EX bundle layout.
package cpu_defs;

  localparam int XLEN_SUPPORTED = 32;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLL = 4'd5,
    ALU_SRL = 4'd6,
    ALU_SRA = 4'd7,
    ALU_BEQ = 4'd8,
    ALU_BNE = 4'd9,
    ALU_BLT = 4'd10,
    ALU_BGE = 4'd11
  } alu_op_e;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_IALU   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_fmt_e;

  // One ID/EX bundle as held in the pipeline register.
  typedef struct packed {
    logic        ex_valid;
    alu_op_e     alu_op;
    logic        alu_b_sel;
    logic [31:0] imm;
    logic [31:0] res1;
    logic [31:0] res2;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jal;
    logic        jalr;
    logic        lui;
    logic        illegal;
  } id_ex_t;

  // A bubble: not valid, no side effects, ADD, all data zero.
  function automatic id_ex_t bubble();
    id_ex_t b;
    b        = '0;
    b.alu_op = ALU_ADD;
    return b;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: extracts and sign-extends the RV32I immediate for the
// selected instruction format. Purely combinational.
module imm_gen
  import cpu_defs::*;
(
  input  logic [31:7] i_instr,
  input  imm_fmt_e    i_fmt,
  output logic [31:0] o_imm
);

  // Reassemble the scattered immediate bits for each format; B and J are
  // halfword offsets so bit 0 is always zero.
  always_comb begin
    o_imm = '0;
    case (i_fmt)
      IMM_I: o_imm = {{20{i_instr[31]}}, i_instr[31:20]};
      IMM_S: o_imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      IMM_B: o_imm = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                      i_instr[30:25], i_instr[11:8], 1'b0};
      IMM_U: o_imm = {i_instr[31:12], 12'd0};
      IMM_J: o_imm = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                      i_instr[20], i_instr[30:21], 1'b0};
      default: o_imm = '0;
    endcase
  end

endmodule

// File: rtl/id_ex_decode.sv
// RV32I decode plus ID/EX pipeline register. The decoded bundle is captured
// on the rising edge; Flush inserts a bubble and takes priority over Stall,
// which holds the register. Every output comes straight from the register.
module id_ex_decode
  import cpu_defs::*;
#(
  parameter int XLEN = 32
)
(
  input  logic            Clock,
  input  logic            Reset,
  input  logic [31:0]     InstrIn,
  input  logic            InstrValid,
  input  logic [XLEN-1:0] PcIn,
  input  logic [XLEN-1:0] RegData1,
  input  logic [XLEN-1:0] RegData2,
  input  logic            Stall,
  input  logic            Flush,
  output logic            ExValid,
  output logic [3:0]      AluOperation,
  output logic            AluBSelect,
  output logic [XLEN-1:0] Immediate,
  output logic [XLEN-1:0] Resource1,
  output logic [XLEN-1:0] Resource2,
  output logic [XLEN-1:0] PcOut,
  output logic [4:0]      Rs1,
  output logic [4:0]      Rs2,
  output logic [4:0]      Rd,
  output logic            RegWrite,
  output logic            MemRead,
  output logic            MemWrite,
  output logic            Branch,
  output logic            Jal,
  output logic            Jalr,
  output logic            Lui,
  output logic            IllegalInstr
);

  logic [6:0]  w_opcode;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  imm_fmt_e    w_fmt;
  logic [31:0] w_imm_raw;
  logic        w_use_imm;
  logic        w_shamt;
  logic        w_legal;
  id_ex_t      w_dec;
  id_ex_t      w_next;
  id_ex_t      r_idex;

  assign w_opcode = InstrIn[6:0];
  assign w_f3     = InstrIn[14:12];
  assign w_f7     = InstrIn[31:25];

  // Immediate format depends only on the opcode.
  always_comb begin
    w_fmt = IMM_I;
    case (w_opcode)
      OPC_STORE:  w_fmt = IMM_S;
      OPC_BRANCH: w_fmt = IMM_B;
      OPC_JAL:    w_fmt = IMM_J;
      OPC_LUI:    w_fmt = IMM_U;
      default:    w_fmt = IMM_I;
    endcase
  end

  imm_gen u_imm_gen (
    .i_instr (InstrIn[31:7]),
    .i_fmt   (w_fmt),
    .o_imm   (w_imm_raw)
  );

  // Decode the instruction into a bundle; unsupported encodings collapse to
  // an ADD with no side effects and the illegal flag set.
  always_comb begin
    w_dec     = bubble();
    w_use_imm = 1'b0;
    w_shamt   = 1'b0;
    w_legal   = 1'b0;

    case (w_opcode)
      OPC_RTYPE: begin
        w_legal         = 1'b1;
        w_dec.reg_write = 1'b1;
        case (w_f3)
          3'b000:  w_dec.alu_op = w_f7[5] ? ALU_SUB : ALU_ADD;
          3'b001:  w_dec.alu_op = ALU_SLL;
          3'b100:  w_dec.alu_op = ALU_XOR;
          3'b101:  w_dec.alu_op = w_f7[5] ? ALU_SRA : ALU_SRL;
          3'b110:  w_dec.alu_op = ALU_OR;
          3'b111:  w_dec.alu_op = ALU_AND;
          default: w_legal = 1'b0;
        endcase
        // funct7 may only be 0, or 0x20 for the SUB/SRA variants.
        if (!((w_f7 == 7'h00) ||
              ((w_f7 == 7'h20) && ((w_f3 == 3'b000) || (w_f3 == 3'b101)))))
          w_legal = 1'b0;
      end
      OPC_IALU: begin
        w_legal         = 1'b1;
        w_dec.reg_write = 1'b1;
        w_dec.alu_b_sel = 1'b1;
        w_use_imm       = 1'b1;
        case (w_f3)
          3'b000: w_dec.alu_op = ALU_ADD;
          3'b001: begin
            w_dec.alu_op = ALU_SLL;
            w_shamt      = 1'b1;
            if (w_f7 != 7'h00) w_legal = 1'b0;
          end
          3'b100: w_dec.alu_op = ALU_XOR;
          3'b101: begin
            w_dec.alu_op = w_f7[5] ? ALU_SRA : ALU_SRL;
            w_shamt      = 1'b1;
            if ((w_f7 != 7'h00) && (w_f7 != 7'h20)) w_legal = 1'b0;
          end
          3'b110:  w_dec.alu_op = ALU_OR;
          3'b111:  w_dec.alu_op = ALU_AND;
          default: w_legal = 1'b0;
        endcase
      end
      OPC_LOAD: begin
        w_legal         = (w_f3 == 3'b010);
        w_dec.alu_b_sel = 1'b1;
        w_use_imm       = 1'b1;
        w_dec.mem_read  = 1'b1;
        w_dec.reg_write = 1'b1;
      end
      OPC_STORE: begin
        w_legal         = (w_f3 == 3'b010);
        w_dec.alu_b_sel = 1'b1;
        w_use_imm       = 1'b1;
        w_dec.mem_write = 1'b1;
      end
      OPC_BRANCH: begin
        w_legal      = 1'b1;
        w_use_imm    = 1'b1;
        w_dec.branch = 1'b1;
        case (w_f3)
          3'b000:  w_dec.alu_op = ALU_BEQ;
          3'b001:  w_dec.alu_op = ALU_BNE;
          3'b100:  w_dec.alu_op = ALU_BLT;
          3'b101:  w_dec.alu_op = ALU_BGE;
          default: w_legal = 1'b0;
        endcase
      end
      OPC_JAL: begin
        w_legal         = 1'b1;
        w_use_imm       = 1'b1;
        w_dec.jal       = 1'b1;
        w_dec.reg_write = 1'b1;
      end
      OPC_JALR: begin
        w_legal         = (w_f3 == 3'b000);
        w_dec.alu_b_sel = 1'b1;
        w_use_imm       = 1'b1;
        w_dec.jalr      = 1'b1;
        w_dec.reg_write = 1'b1;
      end
      OPC_LUI: begin
        w_legal         = 1'b1;
        w_dec.alu_b_sel = 1'b1;
        w_use_imm       = 1'b1;
        w_dec.lui       = 1'b1;
        w_dec.reg_write = 1'b1;
      end
      default: w_legal = 1'b0;
    endcase

    w_dec.ex_valid = 1'b1;
    w_dec.pc       = PcIn;
    w_dec.res1     = RegData1;
    w_dec.res2     = RegData2;
    w_dec.rs1      = InstrIn[19:15];
    w_dec.rs2      = InstrIn[24:20];
    w_dec.rd       = InstrIn[11:7];

    // Shift immediates carry only the zero-extended shift amount.
    if (w_shamt)
      w_dec.imm = {27'd0, InstrIn[24:20]};
    else if (w_use_imm)
      w_dec.imm = w_imm_raw;

    // lui adds the U-immediate to zero.
    if (w_dec.lui)
      w_dec.res1 = '0;

    if (!w_legal) begin
      w_dec.alu_op    = ALU_ADD;
      w_dec.alu_b_sel = 1'b0;
      w_dec.imm       = '0;
      w_dec.reg_write = 1'b0;
      w_dec.mem_read  = 1'b0;
      w_dec.mem_write = 1'b0;
      w_dec.branch    = 1'b0;
      w_dec.jal       = 1'b0;
      w_dec.jalr      = 1'b0;
      w_dec.lui       = 1'b0;
      w_dec.illegal   = 1'b1;
    end

    // Writes to x0 are discarded at decode.
    if (w_dec.rd == 5'd0)
      w_dec.reg_write = 1'b0;
  end

  // A slot without a real instruction becomes a bubble.
  always_comb begin
    w_next = InstrValid ? w_dec : bubble();
  end

  // ID/EX register: reset > flush > stall > load.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)
      r_idex <= bubble();
    else if (Flush)
      r_idex <= bubble();
    else if (!Stall)
      r_idex <= w_next;
  end

  assign ExValid      = r_idex.ex_valid;
  assign AluOperation = r_idex.alu_op;
  assign AluBSelect   = r_idex.alu_b_sel;
  assign Immediate    = r_idex.imm;
  assign Resource1    = r_idex.res1;
  assign Resource2    = r_idex.res2;
  assign PcOut        = r_idex.pc;
  assign Rs1          = r_idex.rs1;
  assign Rs2          = r_idex.rs2;
  assign Rd           = r_idex.rd;
  assign RegWrite     = r_idex.reg_write;
  assign MemRead      = r_idex.mem_read;
  assign MemWrite     = r_idex.mem_write;
  assign Branch       = r_idex.branch;
  assign Jal          = r_idex.jal;
  assign Jalr         = r_idex.jalr;
  assign Lui          = r_idex.lui;
  assign IllegalInstr = r_idex.illegal;

endmodule

// File: tb/tb_id_ex_decode.sv
// Bench for id_ex_decode: directed steps from the test plan followed by
// random instructions with random stall/flush, checked against a
// mnemonic-level reference model.
module tb_id_ex_decode;

  typedef struct packed {
    logic        ex_valid;
    logic [3:0]  alu;
    logic        bsel;
    logic [31:0] imm;
    logic [31:0] res1;
    logic [31:0] res2;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jal;
    logic        jalr;
    logic        lui;
    logic        illegal;
  } bund_t;

  localparam int BW = $bits(bund_t);

  typedef enum {
    M_ADD, M_SUB, M_AND, M_OR, M_XOR, M_SLL, M_SRL, M_SRA,
    M_ADDI, M_ANDI, M_ORI, M_XORI, M_SLLI, M_SRLI, M_SRAI,
    M_LW, M_SW, M_BEQ, M_BNE, M_BLT, M_BGE, M_JAL, M_JALR, M_LUI, M_ILL
  } mnem_e;

  logic        Clock, Reset;
  logic [31:0] InstrIn, PcIn, RegData1, RegData2;
  logic        InstrValid, Stall, Flush;
  logic        ExValid, AluBSelect;
  logic [3:0]  AluOperation;
  logic [31:0] Immediate, Resource1, Resource2, PcOut;
  logic [4:0]  Rs1, Rs2, Rd;
  logic        RegWrite, MemRead, MemWrite, Branch, Jal, Jalr, Lui, IllegalInstr;

  logic [BW-1:0] exp_q[$];
  bund_t         exp_reg;
  int            n_vec = 0;
  int            n_err = 0;

  id_ex_decode #(.XLEN(32)) dut (
    .Clock(Clock), .Reset(Reset), .InstrIn(InstrIn), .InstrValid(InstrValid),
    .PcIn(PcIn), .RegData1(RegData1), .RegData2(RegData2),
    .Stall(Stall), .Flush(Flush),
    .ExValid(ExValid), .AluOperation(AluOperation), .AluBSelect(AluBSelect),
    .Immediate(Immediate), .Resource1(Resource1), .Resource2(Resource2),
    .PcOut(PcOut), .Rs1(Rs1), .Rs2(Rs2), .Rd(Rd),
    .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .Branch(Branch), .Jal(Jal), .Jalr(Jalr), .Lui(Lui),
    .IllegalInstr(IllegalInstr)
  );

  // Clock and reset
  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // ---------------- reference model ----------------
  function automatic mnem_e classify(input logic [31:0] ins);
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = ins[14:12];
    f7 = ins[31:25];
    case (ins[6:0])
      7'h33: begin
        if (f7 == 7'h00) begin
          case (f3)
            3'd0: return M_ADD;
            3'd1: return M_SLL;
            3'd4: return M_XOR;
            3'd5: return M_SRL;
            3'd6: return M_OR;
            3'd7: return M_AND;
            default: return M_ILL;
          endcase
        end
        if (f7 == 7'h20 && f3 == 3'd0) return M_SUB;
        if (f7 == 7'h20 && f3 == 3'd5) return M_SRA;
        return M_ILL;
      end
      7'h13: begin
        case (f3)
          3'd0: return M_ADDI;
          3'd1: return (f7 == 7'h00) ? M_SLLI : M_ILL;
          3'd4: return M_XORI;
          3'd5: begin
            if (f7 == 7'h00) return M_SRLI;
            if (f7 == 7'h20) return M_SRAI;
            return M_ILL;
          end
          3'd6: return M_ORI;
          3'd7: return M_ANDI;
          default: return M_ILL;
        endcase
      end
      7'h03: return (f3 == 3'd2) ? M_LW : M_ILL;
      7'h23: return (f3 == 3'd2) ? M_SW : M_ILL;
      7'h63: begin
        case (f3)
          3'd0: return M_BEQ;
          3'd1: return M_BNE;
          3'd4: return M_BLT;
          3'd5: return M_BGE;
          default: return M_ILL;
        endcase
      end
      7'h6F: return M_JAL;
      7'h67: return (f3 == 3'd0) ? M_JALR : M_ILL;
      7'h37: return M_LUI;
      default: return M_ILL;
    endcase
  endfunction

  function automatic bund_t model(input logic [31:0] ins, input logic v,
                                  input logic [31:0] pc, input logic [31:0] r1,
                                  input logic [31:0] r2);
    bund_t b;
    mnem_e m;
    logic signed [31:0] s;
    logic [31:0] t20, t25, t31;
    b = '0;
    if (!v) return b;
    m   = classify(ins);
    s   = ins;
    t20 = s >>> 20;
    t25 = s >>> 25;
    t31 = s >>> 31;
    b.ex_valid = 1'b1;
    b.pc   = pc;
    b.rs1  = ins[19:15];
    b.rs2  = ins[24:20];
    b.rd   = ins[11:7];
    b.res1 = (m == M_LUI) ? 32'd0 : r1;
    b.res2 = r2;
    case (m)
      M_SUB:          b.alu = 4'd1;
      M_AND, M_ANDI:  b.alu = 4'd2;
      M_OR, M_ORI:    b.alu = 4'd3;
      M_XOR, M_XORI:  b.alu = 4'd4;
      M_SLL, M_SLLI:  b.alu = 4'd5;
      M_SRL, M_SRLI:  b.alu = 4'd6;
      M_SRA, M_SRAI:  b.alu = 4'd7;
      M_BEQ:          b.alu = 4'd8;
      M_BNE:          b.alu = 4'd9;
      M_BLT:          b.alu = 4'd10;
      M_BGE:          b.alu = 4'd11;
      default:        b.alu = 4'd0;
    endcase
    b.bsel = m inside {M_ADDI, M_ANDI, M_ORI, M_XORI, M_SLLI, M_SRLI, M_SRAI,
                       M_LW, M_SW, M_JALR, M_LUI};
    case (m)
      M_ADDI, M_ANDI, M_ORI, M_XORI, M_LW, M_JALR: b.imm = t20;
      M_SLLI, M_SRLI, M_SRAI: b.imm = 32'(ins[24:20]);
      M_SW:  b.imm = (t25 << 5) | 32'(ins[11:7]);
      M_BEQ, M_BNE, M_BLT, M_BGE:
        b.imm = (t31 << 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) |
                (32'(ins[11:8]) << 1);
      M_JAL:
        b.imm = (t31 << 20) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11) |
                (32'(ins[30:21]) << 1);
      M_LUI: b.imm = ins & 32'hFFFF_F000;
      default: b.imm = 32'd0;
    endcase
    b.reg_write = (m inside {M_ADD, M_SUB, M_AND, M_OR, M_XOR, M_SLL, M_SRL, M_SRA,
                             M_ADDI, M_ANDI, M_ORI, M_XORI, M_SLLI, M_SRLI, M_SRAI,
                             M_LW, M_JAL, M_JALR, M_LUI}) && (ins[11:7] != 5'd0);
    b.mem_read  = (m == M_LW);
    b.mem_write = (m == M_SW);
    b.branch    = m inside {M_BEQ, M_BNE, M_BLT, M_BGE};
    b.jal       = (m == M_JAL);
    b.jalr      = (m == M_JALR);
    b.lui       = (m == M_LUI);
    b.illegal   = (m == M_ILL);
    return b;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] w;
    logic [6:0]  opcs [8];
    int k;
    opcs = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37};
    w = $urandom;
    k = $urandom_range(0, 9);
    if (k < 8) begin
      w[6:0] = opcs[k];
      case ($urandom_range(0, 3))
        0: w[31:25] = 7'h00;
        1: w[31:25] = 7'h20;
        default: ;
      endcase
      if ((k == 2 || k == 3) && $urandom_range(0, 3) != 0) w[14:12] = 3'b010;
      if (k == 6 && $urandom_range(0, 3) != 0) w[14:12] = 3'b000;
    end
    return w;
  endfunction

  function automatic bund_t get_obs();
    bund_t o;
    o.ex_valid  = ExValid;      o.alu  = AluOperation; o.bsel = AluBSelect;
    o.imm       = Immediate;    o.res1 = Resource1;    o.res2 = Resource2;
    o.pc        = PcOut;        o.rs1  = Rs1;          o.rs2  = Rs2;
    o.rd        = Rd;           o.reg_write = RegWrite;
    o.mem_read  = MemRead;      o.mem_write = MemWrite;
    o.branch    = Branch;       o.jal  = Jal;          o.jalr = Jalr;
    o.lui       = Lui;          o.illegal = IllegalInstr;
    return o;
  endfunction

  // ---------------- scoreboard / checks ----------------
  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_bund(input string tag, input bund_t exp);
    bund_t obs;
    obs = get_obs();
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [31:0] ins, input logic v, input logic [31:0] pc,
                       input logic [31:0] r1, input logic [31:0] r2,
                       input logic st, input logic fl);
    @(negedge Clock);
    InstrIn = ins; InstrValid = v; PcIn = pc;
    RegData1 = r1; RegData2 = r2; Stall = st; Flush = fl;
    if (fl)       exp_reg = '0;
    else if (!st) exp_reg = model(ins, v, pc, r1, r2);
    exp_q.push_back(exp_reg);
  endtask

  task automatic edge_check(input string tag);
    @(posedge Clock);
    #1;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $error("FAIL %s: observed empty expected queue, required one entry", tag);
    end else begin
      check_bund(tag, exp_q.pop_front());
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    Reset = 1'b1; InstrIn = '0; InstrValid = 1'b0; PcIn = '0;
    RegData1 = '0; RegData2 = '0; Stall = 1'b0; Flush = 1'b0;
    exp_reg = '0;

    #12;
    check_bund("reset_state", '0);
    check_vec("reset_aluop", 32'(AluOperation), 32'd0);
    @(negedge Clock);
    Reset = 1'b0;

    // add x3,x1,x2
    drive(32'h002081B3, 1'b1, 32'h0000_0100, 32'd5, 32'd7, 1'b0, 1'b0);
    edge_check("add_bundle");
    check_vec("add_aluop", 32'(AluOperation), 32'd0);
    check_vec("add_bsel", 32'(AluBSelect), 32'd0);
    check_vec("add_rd", 32'(Rd), 32'd3);
    check_vec("add_regwrite", 32'(RegWrite), 32'd1);
    check_vec("add_res1", Resource1, 32'd5);
    check_vec("add_res2", Resource2, 32'd7);
    check_vec("add_exvalid", 32'(ExValid), 32'd1);

    // addi x1,x0,-1
    drive(32'hFFF00093, 1'b1, 32'h0000_0104, 32'd0, 32'd9, 1'b0, 1'b0);
    edge_check("addi_bundle");
    check_vec("addi_imm", Immediate, 32'hFFFF_FFFF);
    check_vec("addi_bsel", 32'(AluBSelect), 32'd1);
    check_vec("addi_aluop", 32'(AluOperation), 32'd0);
    check_vec("addi_rd", 32'(Rd), 32'd1);

    // beq x1,x2,-8
    drive(32'hFE208CE3, 1'b1, 32'h0000_0108, 32'd1, 32'd2, 1'b0, 1'b0);
    edge_check("beq_bundle");
    check_vec("beq_aluop", 32'(AluOperation), 32'd8);
    check_vec("beq_imm", Immediate, 32'hFFFF_FFF8);
    check_vec("beq_branch", 32'(Branch), 32'd1);
    check_vec("beq_regwrite", 32'(RegWrite), 32'd0);
    check_vec("beq_bsel", 32'(AluBSelect), 32'd0);

    // add x0,x1,x2: write to x0 suppressed
    drive(32'h00208033, 1'b1, 32'h0000_010C, 32'd3, 32'd4, 1'b0, 1'b0);
    edge_check("add_x0_bundle");
    check_vec("add_x0_regwrite", 32'(RegWrite), 32'd0);

    // sw x2,8(x1), then hold for three edges while InstrIn changes
    drive(32'h0020A423, 1'b1, 32'h0000_0110, 32'h1000, 32'hCAFE, 1'b0, 1'b0);
    edge_check("sw_bundle");
    check_vec("sw_imm", Immediate, 32'd8);
    check_vec("sw_memwrite", 32'(MemWrite), 32'd1);
    for (int i = 0; i < 3; i++) begin
      drive(gen_instr(), 1'b1, $urandom, $urandom, $urandom, 1'b1, 1'b0);
      edge_check("stall_hold");
      check_vec("stall_imm", Immediate, 32'd8);
      check_vec("stall_pc", PcOut, 32'h0000_0110);
    end
    drive(32'h002081B3, 1'b1, 32'h0000_0114, 32'd1, 32'd1, 1'b1, 1'b1);
    edge_check("flush_over_stall");
    check_vec("flush_exvalid", 32'(ExValid), 32'd0);
    check_vec("flush_memwrite", 32'(MemWrite), 32'd0);

    // Unsupported opcode
    drive(32'h0000007F, 1'b1, 32'h0000_0118, 32'd6, 32'd8, 1'b0, 1'b0);
    edge_check("illegal_bundle");
    check_vec("illegal_flag", 32'(IllegalInstr), 32'd1);
    check_vec("illegal_exvalid", 32'(ExValid), 32'd1);
    check_vec("illegal_regwrite", 32'(RegWrite), 32'd0);
    check_vec("illegal_memwrite", 32'(MemWrite), 32'd0);

    // InstrValid low loads a bubble
    drive(32'h002081B3, 1'b0, 32'h0000_011C, 32'd5, 32'd7, 1'b0, 1'b0);
    edge_check("invalid_bubble");

    // Asynchronous reset between edges
    drive(32'h002081B3, 1'b1, 32'h0000_0120, 32'd5, 32'd7, 1'b0, 1'b0);
    edge_check("pre_reset_bundle");
    check_vec("pre_reset_exvalid", 32'(ExValid), 32'd1);
    #2;
    Reset = 1'b1;
    #1;
    check_bund("async_reset_clear", '0);
    exp_reg = '0;
    @(negedge Clock);
    Reset = 1'b0;

    // Random traffic with random stall/flush
    for (int i = 0; i < 400; i++) begin
      drive(gen_instr(), ($urandom_range(0, 9) != 0), $urandom & 32'hFFFF_FFFC,
            $urandom, $urandom, ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 9) == 0));
      edge_check("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
